led_sequencer: RTL

Parametrised LED pattern engine for the LogicDeck blade LEDs: a programmable prescaler paces a WIDTH-bit pattern register through one of four selectable sequences (Johnson trail, one-hot rotate, bounce, binary count). It replaces the fixed 6-LED Johnson trail with runtime control of mode, direction and speed, plus single-step and status pulses. It sits between the top-level clock/control logic and the blade LED pins.

---
 rtl/led_sequencer_if.sv | 25 ++
 rtl/led_sequencer.sv | 92 +++++++++
 2 files changed

// File: rtl/led_sequencer_if.sv
// Control and pattern bus for the LED sequencer: control from the master,
// pattern and status pulses from the sequencer.
interface led_sequencer_if #(
  parameter int WIDTH    = 6,
  parameter int DIV_BITS = 23
);
  logic                en;
  logic [1:0]          mode;
  logic                dir;
  logic [DIV_BITS-1:0] period;
  logic                step;
  logic [WIDTH-1:0]    leds;
  logic                tick;
  logic                wrap;

  modport master (
    output en, mode, dir, period, step,
    input  leds, tick, wrap
  );

  modport slave (
    input  en, mode, dir, period, step,
    output leds, tick, wrap
  );
endinterface

// File: rtl/led_sequencer.sv
// LED pattern engine: a prescaler or manual step advances a WIDTH-bit pattern
// through Johnson, rotate, bounce or binary sequences with tick/wrap pulses.
module led_sequencer #(
  parameter int WIDTH    = 6,
  parameter int DIV_BITS = 23
) (
  input  logic            clk,
  input  logic            resetn,
  led_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_JOHNSON = 2'b00,
    MODE_ROTATE  = 2'b01,
    MODE_BOUNCE  = 2'b10,
    MODE_BINARY  = 2'b11
  } mode_t;

  localparam logic [WIDTH-1:0] SEED = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] TOP  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [DIV_BITS-1:0] cnt;
  logic [WIDTH-1:0]    leds_q;
  logic                tick_q;
  logic                wrap_q;
  mode_t               active_mode;
  logic                bounce_up;

  logic                ptick;
  logic                advance;
  logic [WIDTH-1:0]    next_leds;

  // The >= compare lets a shortened period fire on the very next cycle.
  assign ptick   = bus.en && (cnt >= bus.period);
  assign advance = ptick || bus.step;

  always_comb begin
    next_leds = leds_q;
    case (active_mode)
      MODE_JOHNSON: next_leds = bus.dir ? {leds_q[WIDTH-2:0], ~leds_q[WIDTH-1]}
                                        : {~leds_q[0], leds_q[WIDTH-1:1]};
      MODE_ROTATE:  next_leds = bus.dir ? {leds_q[WIDTH-2:0], leds_q[WIDTH-1]}
                                        : {leds_q[0], leds_q[WIDTH-1:1]};
      MODE_BOUNCE:  next_leds = bounce_up ? {leds_q[WIDTH-2:0], 1'b0}
                                          : {1'b0, leds_q[WIDTH-1:1]};
      MODE_BINARY:  next_leds = bus.dir ? leds_q + WIDTH'(1)
                                        : leds_q - WIDTH'(1);
      default:      next_leds = leds_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt         <= '0;
      leds_q      <= SEED;
      tick_q      <= 1'b0;
      wrap_q      <= 1'b0;
      active_mode <= MODE_JOHNSON;
      bounce_up   <= 1'b1;
    end else begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      if (bus.en) begin
        cnt <= ptick ? '0 : cnt + DIV_BITS'(1);
      end
      if (advance) begin
        tick_q <= 1'b1;
        // A mode change spends this advance on reloading the seed.
        if (mode_t'(bus.mode) != active_mode) begin
          leds_q      <= SEED;
          active_mode <= mode_t'(bus.mode);
          bounce_up   <= 1'b1;
        end else begin
          leds_q <= next_leds;
          wrap_q <= (next_leds == SEED);
          if (active_mode == MODE_BOUNCE) begin
            if (next_leds == TOP) begin
              bounce_up <= 1'b0;
            end else if (next_leds == SEED) begin
              bounce_up <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign bus.leds = leds_q;
  assign bus.tick = tick_q;
  assign bus.wrap = wrap_q;

endmodule
